display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit 7-segment display. It generates the 2-bit digit select that drives the 4-to-1 digit mux and the matching active-low anode enables. Each digit slot starts with a dead-time blanking interval to prevent ghosting. Leading-zero suppression is optional. It sits directly upstream of the digit mux and in parallel with the segment decoder.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, anode-off dead time at the start of each slot; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  scan enable; low forces the IDLE state
lz_blank_en  input  1  enables leading-zero suppression
digit_zero  input  4  bit i is high when digit i value is zero; digit 3 is most significant
sel  output  2  digit select to the mux; 0 = digit 0 (least significant)
an  output  4  anode enables, active low; an[i] drives digit i
slot_tick  output  1  one-cycle pulse on the first cycle of every slot
frame_tick  output  1  one-cycle pulse on the first cycle of the slot where sel wraps from 3 to 0

Behaviour:
- All outputs are registered. Slot counter div_cnt is $clog2(REFRESH_DIV) bits wide.
- Reset (rst=1 at a clock edge) takes priority over everything, including mid-slot. Next cycle values:
  - state = IDLE, div_cnt = 0, sel = 0
  - an = 4'b1111, slot_tick = 0, frame_tick = 0
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - an = 4'hF, sel = 0, div_cnt = 0, no ticks.
  - If en=1 is sampled, the next cycle has div_cnt = 0, sel = 0 and slot_tick = 1.
  - That next state is BLANK, or DRIVE if BLANK_CYCLES = 0.
  - frame_tick stays 0 on this first slot.
- BLANK:
  - an = 4'hF; sel already holds the new digit so the mux and decoder settle.
  - div_cnt increments each cycle.
  - When div_cnt = BLANK_CYCLES-1, the next state is DRIVE.
- DRIVE:
  - an = ~(4'b0001 << sel) unless the current digit is suppressed, in which case an = 4'hF.
  - an is recomputed every cycle from the digit_zero sampled on the previous edge, so latency is 1 cycle.
- Slot end: when div_cnt = REFRESH_DIV-1 (in BLANK or DRIVE), the next cycle has:
  - div_cnt = 0 and sel = sel+1 (mod 4, 3 wraps to 0)
  - state = BLANK (or DRIVE if BLANK_CYCLES = 0)
  - an = 4'hF if the next state is BLANK
  - slot_tick = 1, and frame_tick = 1 if the old sel was 3
- Slot length is exactly REFRESH_DIV cycles and a frame is 4*REFRESH_DIV cycles. Anodes are active for REFRESH_DIV-BLANK_CYCLES cycles per slot.
- Leading-zero suppression: digit i (i = 1..3) is suppressed when all of these hold:
  - lz_blank_en = 1
  - digit_zero[i] = 1
  - digit_zero[j] = 1 for every j > i
- Digit 0 is never suppressed, so the value 0 shows a single "0".
- en deasserted at any point, mid-slot included: the next cycle is IDLE with the IDLE output values. A pending slot_tick or frame_tick is not issued.
- en held high: scanning is free-running and never stalls.
- At most one anode is low in any cycle. an is never low in the same cycle as a slot_tick that begins a BLANK slot.

Test Plan:
1. REFRESH_DIV=8, BLANK_CYCLES=2, rst for 3 cycles, then en=1, lz_blank_en=0 -> first slot_tick 1 cycle after en is sampled with sel=0.
   - an=F for 2 cycles, then 4'b1110 for 6 cycles.
   - sel steps 0,1,2,3,0 every 8 cycles; frame_tick is high only on the sel 3->0 slot start, 32 cycles apart.
2. Same config, lz_blank_en=1, digit_zero=4'b1100 -> in DRIVE, an stays F in slots 3 and 2; slot 1 gives 4'b1101 and slot 0 gives 4'b1110.
   - digit_zero=4'b1111: only slot 0 lights, an=4'b1110.
   - digit_zero=4'b0101: all four digits light.
3. Same config, en dropped at div_cnt=5 in slot 2 -> next cycle an=F, sel=0, no ticks.
   - Re-asserting en restarts at sel=0 with slot_tick=1 and frame_tick=0.
4. rst asserted during DRIVE of slot 3 -> next cycle all outputs at reset values.
   - After release with en=1, no frame_tick is issued until a full 3->0 wrap.
5. BLANK_CYCLES=0, REFRESH_DIV=2 -> an is active on every cycle and rotates 1110,1110,1101,1101,... with sel changing every 2 cycles.
   - Never more than one anode is low in any cycle (assertion checked throughout).

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: rotates the digit select,
// blanks the anodes at the start of each slot, and optionally hides leading zeros.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lz_blank_en,
  input  logic [3:0] digit_zero,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       slot_tick,
  output logic       frame_tick
);

  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] LAST_CNT  = W'(REFRESH_DIV - 1);
  localparam logic [W-1:0] BLANK_END = W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t       state_reg, state_next;
  logic [W-1:0] div_cnt_reg, div_cnt_next;
  logic [1:0]   sel_reg, sel_next;
  logic [3:0]   an_reg, an_next;
  logic         slot_tick_reg, slot_tick_next;
  logic         frame_tick_reg, frame_tick_next;
  logic [3:0]   zero_run;

  // zero_run[i]: digit i and every more significant digit are zero
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero_run
      assign zero_run[gi] = lz_blank_en && (&digit_zero[3:gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      sel_reg        <= 2'd0;
      an_reg         <= 4'hF;
      slot_tick_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      sel_reg        <= sel_next;
      an_reg         <= an_next;
      slot_tick_reg  <= slot_tick_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  always_comb begin
    state_next      = IDLE;
    div_cnt_next    = '0;
    sel_next        = 2'd0;
    slot_tick_next  = 1'b0;
    frame_tick_next = 1'b0;
    an_next         = 4'hF;

    if (en) begin
      unique case (state_reg)
        IDLE: begin
          state_next     = SLOT_START;
          slot_tick_next = 1'b1;
        end
        BLANK, DRIVE: begin
          sel_next   = sel_reg;
          state_next = state_reg;
          if (div_cnt_reg == LAST_CNT) begin
            state_next      = SLOT_START;
            sel_next        = sel_reg + 2'd1;
            slot_tick_next  = 1'b1;
            frame_tick_next = (sel_reg == 2'd3);
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
            if (state_reg == BLANK && div_cnt_reg == BLANK_END)
              state_next = DRIVE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Digit 0 is never hidden so a zero value still shows one "0"
    if (state_next == DRIVE && !(zero_run[sel_next] && sel_next != 2'd0))
      an_next = ~(4'b0001 << sel_next);
  end

  assign sel        = sel_reg;
  assign an         = an_reg;
  assign slot_tick  = slot_tick_reg;
  assign frame_tick = frame_tick_reg;

endmodule
